// File: rtl/ds_pkg.sv
// Shared widths and FSM state encoding for the downstream cancelled-orders table writer.
package ds_pkg;

    localparam int CLIENT_W = 5;
    localparam int DATA_W   = 32;
    localparam int DEPTH    = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        ADD   = 3'd2,
        WRITE = 3'd3,
        CLEAR = 3'd4
    } ds_state_t;

endpackage

// File: rtl/ds_cancel_ram.sv
// DEPTH x DATA_W table RAM: one write port, two registered read ports (RMW and upstream).
// Reads are read-before-write; the array itself is not reset.
module ds_cancel_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [ADDR_W-1:0] rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] ra_data_q;
    logic [DATA_W-1:0] rb_data_q;

    // Storage write and both registered reads; old data is returned on a same-address write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        ra_data_q <= mem_q[ra_addr_i];
        rb_data_q <= mem_q[rb_addr_i];
    end

    assign ra_data_o = ra_data_q;
    assign rb_data_o = rb_data_q;

endmodule

// File: rtl/downstream_cancel_writer.sv
// Accumulates cancel reports into a per-client cancelled total via read-modify-write.
// Optional DS_SATURATE_EN: a carry out of the add saturates the total and pulses overflow.
module downstream_cancel_writer #(
    parameter int DATA_W   = ds_pkg::DATA_W,
    parameter int CLIENT_W = ds_pkg::CLIENT_W,
    parameter int DEPTH    = ds_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                HRESETn,
    input  logic                cancel_valid,
    output logic                cancel_ready,
    input  logic [CLIENT_W-1:0] cancel_client_id,
    input  logic [DATA_W-1:0]   cancel_amount,
    input  logic                clear_valid,
    input  logic [CLIENT_W-1:0] clear_client_id,
    input  logic [CLIENT_W-1:0] rd_client_id,
    output logic [DATA_W-1:0]   rd_cancelled,
    output logic                cancel_done,
    output logic                overflow,
    output logic                busy
);
    import ds_pkg::*;

`ifdef DS_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    ds_state_t           state_q, state_d;
    logic [CLIENT_W-1:0] client_q, client_d;
    logic [DATA_W-1:0]   amount_q, amount_d;
    logic [DATA_W-1:0]   old_q, old_d;
    logic [DATA_W:0]     sum_q, sum_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic                cancel_done_q;
    logic                overflow_q;
    logic                rd_valid_q;

    logic                ram_we_s;
    logic [CLIENT_W-1:0] ram_raddr_s;
    logic [DATA_W-1:0]   ram_wdata_s;
    logic [DATA_W-1:0]   ram_rmw_data_s;
    logic [DATA_W-1:0]   ram_rd_data_s;
    logic                sat_q_s;
    logic                sat_d_s;

    assign sat_q_s = SAT_EN & sum_q[DATA_W];
    assign sat_d_s = SAT_EN & sum_d[DATA_W];

    ds_cancel_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (CLIENT_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk       (clk),
        .we_i      (ram_we_s),
        .waddr_i   (client_q),
        .wdata_i   (ram_wdata_s),
        .ra_addr_i (ram_raddr_s),
        .ra_data_o (ram_rmw_data_s),
        .rb_addr_i (rd_client_id),
        .rb_data_o (ram_rd_data_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a clear beats a same-cycle cancel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (clear_valid) begin
                    state_d = CLEAR;
                end else if (cancel_valid) begin
                    state_d = READ;
                end else begin
                    state_d = IDLE;
                end
            end
            READ:    state_d = ADD;
            ADD:     state_d = WRITE;
            WRITE:   state_d = IDLE;
            CLEAR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake, RMW read address and table write.
    always_comb begin
        cancel_ready = 1'b0;
        ram_raddr_s  = client_q;
        ram_we_s     = 1'b0;
        ram_wdata_s  = '0;
        case (state_q)
            IDLE: begin
                cancel_ready = ~clear_valid;
                ram_raddr_s  = cancel_client_id;
            end
            WRITE: begin
                ram_we_s    = 1'b1;
                ram_wdata_s = sat_q_s ? {DATA_W{1'b1}} : sum_q[DATA_W-1:0];
            end
            CLEAR: begin
                ram_we_s    = 1'b1;
                ram_wdata_s = '0;
            end
            default: begin
                cancel_ready = 1'b0;
            end
        endcase
    end

    // Datapath next values: latch on accept, mask stale RAM data, form the wide sum.
    always_comb begin
        client_d = client_q;
        amount_d = amount_q;
        old_d    = old_q;
        sum_d    = sum_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (clear_valid) begin
                    client_d = clear_client_id;
                end else if (cancel_valid) begin
                    client_d = cancel_client_id;
                    amount_d = cancel_amount;
                end else begin
                    client_d = client_q;
                end
            end
            READ:    old_d = valid_q[client_q] ? ram_rmw_data_s : '0;
            ADD:     sum_d = {1'b0, old_q} + {1'b0, amount_q};
            default: sum_d = sum_q;
        endcase
        if (ram_we_s) begin
            valid_d[client_q] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Datapath, valid bits and registered status pulses.
    always_ff @(posedge clk or negedge HRESETn) begin
        if (!HRESETn) begin
            client_q      <= '0;
            amount_q      <= '0;
            old_q         <= '0;
            sum_q         <= '0;
            valid_q       <= '0;
            cancel_done_q <= 1'b0;
            overflow_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
        end else begin
            client_q      <= client_d;
            amount_q      <= amount_d;
            old_q         <= old_d;
            sum_q         <= sum_d;
            valid_q       <= valid_d;
            cancel_done_q <= (state_d == WRITE);
            overflow_q    <= (state_d == WRITE) & sat_d_s;
            rd_valid_q    <= valid_q[rd_client_id];
        end
    end

    assign rd_cancelled = rd_valid_q ? ram_rd_data_s : '0;
    assign cancel_done  = cancel_done_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_downstream_cancel_writer.sv
// Directed bench for downstream_cancel_writer with a reference table model and a read scoreboard.
// Honors DS_SATURATE_EN for the expected overflow behaviour.
module tb_downstream_cancel_writer;

    logic        clk = 1'b0;
    logic        HRESETn;
    logic        cancel_valid;
    logic        cancel_ready;
    logic [4:0]  cancel_client_id;
    logic [31:0] cancel_amount;
    logic        clear_valid;
    logic [4:0]  clear_client_id;
    logic [4:0]  rd_client_id;
    logic [31:0] rd_cancelled;
    logic        cancel_done;
    logic        overflow;
    logic        busy;

    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] model [32];
    logic [31:0] exp_q [$];
    logic        exp_ovf;

    downstream_cancel_writer dut (
        .clk              (clk),
        .HRESETn          (HRESETn),
        .cancel_valid     (cancel_valid),
        .cancel_ready     (cancel_ready),
        .cancel_client_id (cancel_client_id),
        .cancel_amount    (cancel_amount),
        .clear_valid      (clear_valid),
        .clear_client_id  (clear_client_id),
        .rd_client_id     (rd_client_id),
        .rd_cancelled     (rd_cancelled),
        .cancel_done      (cancel_done),
        .overflow         (overflow),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic predict(input logic [4:0] id, input logic [31:0] amt);
        logic [32:0] s;
        s = {1'b0, model[id]} + {1'b0, amt};
`ifdef DS_SATURATE_EN
        exp_ovf   = s[32];
        model[id] = s[32] ? 32'hFFFF_FFFF : s[31:0];
`else
        exp_ovf   = 1'b0;
        model[id] = s[31:0];
`endif
    endtask

    // Current time is the negedge of cycle 1 after accept; done must appear in cycle 3.
    task automatic wait_done();
        int n;
        n = 1;
        while (!cancel_done && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk("done_latency", n, 32'd3);
        chk("overflow", {31'd0, overflow}, {31'd0, exp_ovf});
        @(negedge clk);
        chk("done_pulse_end", {31'd0, cancel_done}, 32'd0);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cancel_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, cancel_ready}, 32'd1);
    endtask

    task automatic do_cancel(input logic [4:0] id, input logic [31:0] amt);
        @(negedge clk);
        cancel_valid     = 1'b1;
        cancel_client_id = id;
        cancel_amount    = amt;
        wait_ready();
        @(negedge clk);
        cancel_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        predict(id, amt);
        wait_done();
    endtask

    task automatic rd_check(input logic [4:0] id);
        @(negedge clk);
        rd_client_id = id;
        exp_q.push_back(model[id]);
        @(negedge clk);
        chk("rd_cancelled", rd_cancelled, exp_q.pop_front());
    endtask

    initial begin
        int low;
        HRESETn          = 1'b0;
        cancel_valid     = 1'b0;
        cancel_client_id = 5'd0;
        cancel_amount    = 32'd0;
        clear_valid      = 1'b0;
        clear_client_id  = 5'd0;
        rd_client_id     = 5'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cancel_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, cancel_done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_rd", rd_cancelled, 32'd0);
        HRESETn = 1'b1;

        for (int i = 0; i < 32; i++) rd_check(i[4:0]);

        // Two separate cancels accumulate.
        do_cancel(5'd3, 32'd100);
        do_cancel(5'd3, 32'd50);
        rd_check(5'd3);
        chk("model_150", model[3], 32'd150);

        // Zero amount still completes and leaves the total unchanged.
        do_cancel(5'd3, 32'd0);
        rd_check(5'd3);

        // Back-to-back with valid held high.
        @(negedge clk);
        cancel_valid     = 1'b1;
        cancel_client_id = 5'd3;
        cancel_amount    = 32'd7;
        wait_ready();
        @(negedge clk);
        predict(5'd3, 32'd7);
        cancel_amount = 32'd11;
        low = 0;
        while (!cancel_ready && low < 10) begin
            low++;
            @(negedge clk);
        end
        chk("b2b_ready_low", low, 32'd3);
        @(negedge clk);
        cancel_valid = 1'b0;
        predict(5'd3, 32'd11);
        wait_done();
        rd_check(5'd3);

        // Same-cycle clear and cancel: clear wins, cancel follows.
        @(negedge clk);
        clear_valid      = 1'b1;
        clear_client_id  = 5'd3;
        cancel_valid     = 1'b1;
        cancel_client_id = 5'd3;
        cancel_amount    = 32'd25;
        #1;
        chk("clear_prio_ready", {31'd0, cancel_ready}, 32'd0);
        @(negedge clk);
        clear_valid = 1'b0;
        chk("clear_busy", {31'd0, busy}, 32'd1);
        model[3] = 32'd0;
        wait_ready();
        @(negedge clk);
        cancel_valid = 1'b0;
        predict(5'd3, 32'd25);
        wait_done();
        rd_check(5'd3);

        // Carry out of the add.
        do_cancel(5'd7, 32'hFFFF_FFF0);
        do_cancel(5'd7, 32'h0000_0020);
        rd_check(5'd7);
        rd_check(5'd0);

        // Reset during READ discards the report and empties the table.
        @(negedge clk);
        cancel_valid     = 1'b1;
        cancel_client_id = 5'd9;
        cancel_amount    = 32'd5;
        wait_ready();
        @(negedge clk);
        cancel_valid = 1'b0;
        HRESETn      = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_done", {31'd0, cancel_done}, 32'd0);
        end
        HRESETn = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        rd_check(5'd9);
        rd_check(5'd3);
        rd_check(5'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
